// File: rtl/ids_arb_pkg.sv
// Shared types and widths for the IDS RX arbiter slice.
package ids_arb_pkg;

    localparam int unsigned DEC_BITS       = 25;
    localparam int unsigned QPN_BITS       = 24;
    localparam int unsigned AXIS_DATA_BITS = 512;
    localparam int unsigned AXIS_KEEP_BITS = 64;
    localparam int unsigned STAT_BITS      = 32;

    // Decision word returned by the decider: QPN in the upper bits, intrusion flag at bit 0.
    typedef struct packed {
        logic [QPN_BITS-1:0] qpn;
        logic                intr;
    } ids_decision_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ids_tag_fifo.sv
// In-order tag FIFO: remembers which source each granted packet came from.
module ids_tag_fifo
    import ids_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_c,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_nxt;

    // Qualify requests and compute the next occupancy.
    always_comb begin
        w_do_push   = i_push && !r_full;
        w_do_pop    = i_pop && !r_empty;
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers and flags; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since the flags guard every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/ids_rx_arbiter.sv
// Packet-granular round-robin arbiter sharing one IDS pipeline among N_SRC RX
// streams, with in-order steering of the returned decisions.
// Optional per-source statistics counters: define IDS_RX_ARB_STATS_EN.
module ids_rx_arbiter
    import ids_arb_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                              nclk,
    input  logic                              nresetn,
    input  logic [N_SRC*AXIS_DATA_BITS-1:0]   s_axis_rx_tdata,
    input  logic [N_SRC*AXIS_KEEP_BITS-1:0]   s_axis_rx_tkeep,
    input  logic [N_SRC-1:0]                  s_axis_rx_tvalid,
    input  logic [N_SRC-1:0]                  s_axis_rx_tlast,
    output logic [N_SRC-1:0]                  s_axis_rx_tready,
    output logic [AXIS_DATA_BITS-1:0]         m_axis_tx_tdata,
    output logic [AXIS_KEEP_BITS-1:0]         m_axis_tx_tkeep,
    output logic                              m_axis_tx_tvalid,
    output logic                              m_axis_tx_tlast,
    input  logic                              m_axis_tx_tready,
    input  logic [DEC_BITS-1:0]               s_dec_data,
    input  logic                              s_dec_valid,
    output logic                              s_dec_ready,
    output logic [DEC_BITS-1:0]               m_dec_data,
    output logic [N_SRC-1:0]                  m_dec_valid,
    input  logic [N_SRC-1:0]                  m_dec_ready,
    output logic [$clog2(TAG_DEPTH):0]        tag_count_o,
    output logic                              err_orphan_o
`ifdef IDS_RX_ARB_STATS_EN
    ,
    input  logic                              stat_clr_i,
    output logic [N_SRC*STAT_BITS-1:0]        stat_pkts_o,
    output logic [N_SRC*STAT_BITS-1:0]        stat_intr_o
`endif
);

    localparam int unsigned SRC_BITS = (N_SRC > 2) ? $clog2(N_SRC) : 1;

    arb_state_t          r_state;
    logic [SRC_BITS-1:0] r_grant;
    logic [SRC_BITS-1:0] r_rr_ptr;
    logic                r_active;
    logic                r_err_orphan;

    logic                w_any;
    logic [SRC_BITS-1:0] w_sel;
    logic [SRC_BITS-1:0] w_idx;
    logic                w_push;
    logic                w_pop;
    logic                w_beat_last;
    logic                w_orphan;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [SRC_BITS-1:0] w_head;

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            w_idx = SRC_BITS'((32'(r_rr_ptr) + k) % N_SRC);
            if (!w_any && s_axis_rx_tvalid[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_push = (r_state == IDLE) && w_any && !w_fifo_full;

    // Zero-latency pass-through of the granted source while a packet is open.
    always_comb begin
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tlast  = 1'b0;
        s_axis_rx_tready = '0;
        if (r_state == XFER) begin
            m_axis_tx_tdata  = s_axis_rx_tdata[32'(r_grant)*AXIS_DATA_BITS +: AXIS_DATA_BITS];
            m_axis_tx_tkeep  = s_axis_rx_tkeep[32'(r_grant)*AXIS_KEEP_BITS +: AXIS_KEEP_BITS];
            m_axis_tx_tvalid = s_axis_rx_tvalid[r_grant];
            m_axis_tx_tlast  = s_axis_rx_tlast[r_grant];
            s_axis_rx_tready[r_grant] = m_axis_tx_tready;
        end
    end

    assign w_beat_last = (r_state == XFER) && m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast;

    // Steer each decision to the source at the FIFO head; swallow it when nothing is pending.
    always_comb begin
        m_dec_data  = s_dec_data;
        m_dec_valid = '0;
        s_dec_ready = 1'b0;
        w_pop       = 1'b0;
        if (!w_fifo_empty) begin
            m_dec_valid[w_head] = s_dec_valid;
            s_dec_ready         = m_dec_ready[w_head];
            w_pop               = s_dec_valid && m_dec_ready[w_head];
        end else begin
            s_dec_ready = r_active;
        end
    end

    assign w_orphan = w_fifo_empty && s_dec_valid && r_active;

    // Arbiter FSM plus the sticky orphan flag; r_active keeps s_dec_ready low during reset.
    always_ff @(posedge nclk or negedge nresetn) begin
        if (!nresetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= SRC_BITS'(N_SRC - 1);
            r_active     <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_orphan) r_err_orphan <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_grant  <= w_sel;
                        r_rr_ptr <= w_sel;
                        r_state  <= XFER;
                    end
                end
                XFER: begin
                    if (w_beat_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign err_orphan_o = r_err_orphan;

    ids_tag_fifo #(
        .WIDTH (SRC_BITS),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk       (nclk),
        .i_rst_n     (nresetn),
        .i_push      (w_push),
        .i_push_data (w_sel),
        .i_pop       (w_pop),
        .o_head_c    (w_head),
        .o_count     (tag_count_o),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

`ifdef IDS_RX_ARB_STATS_EN
    ids_decision_t w_dec;
    assign w_dec = ids_decision_t'(s_dec_data);

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_stat
        logic [STAT_BITS-1:0] r_pkts;
        logic [STAT_BITS-1:0] r_intr;

        // Saturating grant and intrusion counters for one source.
        always_ff @(posedge nclk or negedge nresetn) begin
            if (!nresetn) begin
                r_pkts <= '0;
                r_intr <= '0;
            end else if (stat_clr_i) begin
                r_pkts <= '0;
                r_intr <= '0;
            end else begin
                if (w_push && (w_sel == SRC_BITS'(gi)) && (r_pkts != '1))
                    r_pkts <= r_pkts + STAT_BITS'(1);
                if (w_pop && w_dec.intr && (w_head == SRC_BITS'(gi)) && (r_intr != '1))
                    r_intr <= r_intr + STAT_BITS'(1);
            end
        end

        assign stat_pkts_o[gi*STAT_BITS +: STAT_BITS] = r_pkts;
        assign stat_intr_o[gi*STAT_BITS +: STAT_BITS] = r_intr;
    end
`endif

endmodule
